mac_lookup_scheduler: RTL and testbench

//  Shares the single datapath read port of the MAC-table BRAM (8-bit address, 48-bit MAC data) among NUM_REQ lookup clients.
//  - Grants in round-robin order, one transaction outstanding at a time.
//  - Runs the read handshake on the clients' behalf and routes the returned MAC to the granted client.
//  - Aborts a transaction that exceeds a cycle budget.
//  - Sits between the per-port lookup engines and the read port 0 of the BRAM arbiter.

---
 rtl/mac_lookup_scheduler.sv | 130 +++++++++++++
 tb/tb_mac_lookup_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lookup_scheduler.sv
// Round-robin scheduler sharing the MAC-table BRAM read port among NUM_REQ lookup clients.
// One read is outstanding at a time; a read that overruns TIMEOUT cycles is aborted.
module mac_lookup_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 64,
  parameter int TO_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    cli_req,
  input  logic [8*NUM_REQ-1:0]  cli_addr,
  output logic [NUM_REQ-1:0]    cli_done,
  output logic [NUM_REQ-1:0]    cli_err,
  output logic [47:0]           cli_data,
  output logic                  bram_read_req,
  output logic [7:0]            bram_read_add,
  input  logic                  bram_read_ack,
  input  logic                  bram_read_valid,
  input  logic [47:0]           mac_add_in,
  output logic                  busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ABORT} state_t;

  state_t              state, next_state;
  logic [IDXW-1:0]     idx, rr_ptr, pick, cand, next_rr;
  logic [7:0]          addr_sel;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                grant, capture, advance, timed_out;

  // Walk downwards from the farthest offset so the client closest to rr_ptr wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDXW'((int'(rr_ptr) + i) % NUM_REQ);
      if (cli_req[cand]) pick = cand;
    end
  end

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDXW'(i)) addr_sel = cli_addr[8*i +: 8];
    end
  end

  assign next_rr   = (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + IDXW'(1);
  assign timed_out = (to_cnt == TO_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The timeout check takes priority, so an ack/valid landing on the last cycle is dropped.
  always_comb begin
    next_state    = state;
    grant         = 1'b0;
    capture       = 1'b0;
    advance       = 1'b0;
    bram_read_req = 1'b0;
    busy          = (state != IDLE);
    cli_done      = '0;
    cli_err       = '0;
    case (state)
      IDLE: begin
        if (|cli_req) begin
          grant      = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        bram_read_req = 1'b1;
        if (timed_out) begin
          next_state = ABORT;
        end else if (bram_read_ack) begin
          if (bram_read_valid) begin
            capture    = 1'b1;
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (timed_out) begin
          next_state = ABORT;
        end else if (bram_read_valid) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) cli_done[i] = (idx == IDXW'(i));
        advance    = 1'b1;
        next_state = IDLE;
      end
      ABORT: begin
        for (int i = 0; i < NUM_REQ; i++) cli_err[i] = (idx == IDXW'(i));
        advance    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx           <= '0;
      rr_ptr        <= '0;
      to_cnt        <= '0;
      bram_read_add <= '0;
      cli_data      <= '0;
    end else begin
      if (grant) begin
        idx           <= pick;
        bram_read_add <= addr_sel;
        to_cnt        <= '0;
      end else if (state == REQ || state == WAIT) begin
        to_cnt <= to_cnt + TO_WIDTH'(1);
      end
      if (capture) cli_data <= mac_add_in;
      if (advance) rr_ptr <= next_rr;
    end
  end

endmodule

// File: tb/tb_mac_lookup_scheduler.sv
// Directed testbench for mac_lookup_scheduler: handshake latency, round-robin order,
// zero-wait reads, timeout abort, address stability and asynchronous reset.
module tb_mac_lookup_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cli_req;
  logic [31:0] cli_addr;
  logic [3:0]  cli_done;
  logic [3:0]  cli_err;
  logic [47:0] cli_data;
  logic        bram_read_req;
  logic [7:0]  bram_read_add;
  logic        bram_read_ack;
  logic        bram_read_valid;
  logic [47:0] mac_add_in;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  logic to_bad;

  mac_lookup_scheduler #(.NUM_REQ(4), .TIMEOUT(64), .TO_WIDTH(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .cli_req         (cli_req),
    .cli_addr        (cli_addr),
    .cli_done        (cli_done),
    .cli_err         (cli_err),
    .cli_data        (cli_data),
    .bram_read_req   (bram_read_req),
    .bram_read_add   (bram_read_add),
    .bram_read_ack   (bram_read_ack),
    .bram_read_valid (bram_read_valid),
    .mac_add_in      (mac_add_in),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic valid, input logic [47:0] mac);
    bram_read_ack   = ack;
    bram_read_valid = valid;
    mac_add_in      = mac;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Serves one transaction starting in its REQ cycle: ack, then valid, then checks the response.
  task automatic serve(input int exp_idx, input logic [7:0] exp_addr, input logic [47:0] mac);
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_idx;
    checkOutput("rr_req", {47'd0, bram_read_req}, 48'd1);
    checkOutput("rr_addr", {40'd0, bram_read_add}, {40'd0, exp_addr});
    applyStimulus(1'b1, 1'b0, 48'd0);
    tick();
    applyStimulus(1'b0, 1'b1, mac);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("rr_done", {44'd0, cli_done}, {44'd0, onehot});
    checkOutput("rr_data", cli_data, mac);
    tick();
    checkOutput("rr_single", {44'd0, cli_done}, 48'd0);
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    cli_req  = '0;
    cli_addr = '0;
    applyStimulus(1'b0, 1'b0, 48'd0);
    #1 reset = 1'b0;
    tick();
    checkOutput("rst_req",  {47'd0, bram_read_req}, 48'd0);
    checkOutput("rst_busy", {47'd0, busy}, 48'd0);
    checkOutput("rst_done", {44'd0, cli_done}, 48'd0);
    checkOutput("rst_err",  {44'd0, cli_err}, 48'd0);
    checkOutput("rst_data", cli_data, 48'd0);
    checkOutput("rst_addr", {40'd0, bram_read_add}, 48'd0);
    tick();
    reset = 1'b1;

    // Single client 1, ack at cycle 1, valid at cycle 3.
    cli_req  = 4'b0010;
    cli_addr = 32'h0000_2A00;
    tick();
    checkOutput("t1_req",  {47'd0, bram_read_req}, 48'd1);
    checkOutput("t1_addr", {40'd0, bram_read_add}, 48'h2A);
    applyStimulus(1'b1, 1'b0, 48'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("t1_wait_req", {47'd0, bram_read_req}, 48'd0);
    checkOutput("t1_wait_busy", {47'd0, busy}, 48'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 48'h0011_2233_4455);
    checkOutput("t1_no_early_done", {44'd0, cli_done}, 48'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    cli_req = 4'b0000;
    checkOutput("t1_done", {44'd0, cli_done}, 48'b0010);
    checkOutput("t1_data", cli_data, 48'h0011_2233_4455);
    tick();
    checkOutput("t1_done_clr", {44'd0, cli_done}, 48'd0);
    checkOutput("t1_idle", {47'd0, busy}, 48'd0);

    // All four clients from reset: grants 0,1,2,3,0.
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    cli_addr = 32'h4433_2211;
    cli_req  = 4'b1111;
    tick();
    serve(0, 8'h11, 48'hA0A0_0000_0000);
    serve(1, 8'h22, 48'hA1A1_0000_0001);
    serve(2, 8'h33, 48'hA2A2_0000_0002);
    serve(3, 8'h44, 48'hA3A3_0000_0003);
    serve(0, 8'h11, 48'hA4A4_0000_0004);

    // Zero-wait read for client 1, which drops its request mid-transaction.
    checkOutput("t3_req",  {47'd0, bram_read_req}, 48'd1);
    checkOutput("t3_addr", {40'd0, bram_read_add}, 48'h22);
    applyStimulus(1'b1, 1'b1, 48'h0BAD_CAFE_0001);
    cli_req  = 4'b0100;
    cli_addr = 32'h4410_2211;
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("t3_done", {44'd0, cli_done}, 48'b0010);
    checkOutput("t3_data", cli_data, 48'h0BAD_CAFE_0001);
    checkOutput("t3_req_low", {47'd0, bram_read_req}, 48'd0);
    tick();
    checkOutput("t3_idle", {47'd0, busy}, 48'd0);
    checkOutput("t3_gap_req", {47'd0, bram_read_req}, 48'd0);
    tick();

    // Client 2 changes its address while its read sits in WAIT.
    checkOutput("t5_req",  {47'd0, bram_read_req}, 48'd1);
    checkOutput("t5_addr", {40'd0, bram_read_add}, 48'h10);
    applyStimulus(1'b1, 1'b0, 48'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    cli_addr = 32'h4420_2211;
    checkOutput("t5_wait_busy", {47'd0, busy}, 48'd1);
    tick();
    checkOutput("t5_addr_hold", {40'd0, bram_read_add}, 48'h10);
    applyStimulus(1'b0, 1'b1, 48'h5555_6666_7777);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    cli_req = 4'b0000;
    checkOutput("t5_done", {44'd0, cli_done}, 48'b0100);
    checkOutput("t5_data", cli_data, 48'h5555_6666_7777);
    tick();

    // Client 3 never gets a valid: abort 64 cycles after the request rose.
    cli_req = 4'b1000;
    tick();
    checkOutput("t4_req", {47'd0, bram_read_req}, 48'd1);
    cli_req = 4'b0000;
    to_bad  = 1'b0;
    for (int c = 1; c < 64; c++) begin
      if (cli_err !== 4'b0000 || bram_read_req !== 1'b1) to_bad = 1'b1;
      tick();
    end
    if (cli_err !== 4'b0000 || bram_read_req !== 1'b1) to_bad = 1'b1;
    checkOutput("t4_quiet_before_abort", {47'd0, to_bad}, 48'd0);
    applyStimulus(1'b1, 1'b1, 48'hDEAD_DEAD_DEAD);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("t4_err",  {44'd0, cli_err}, 48'b1000);
    checkOutput("t4_no_done", {44'd0, cli_done}, 48'd0);
    checkOutput("t4_req_low", {47'd0, bram_read_req}, 48'd0);
    checkOutput("t4_data_kept", cli_data, 48'h5555_6666_7777);
    tick();
    checkOutput("t4_err_clr", {44'd0, cli_err}, 48'd0);
    applyStimulus(1'b1, 1'b1, 48'hBEEF_BEEF_BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("t4_late_done", {44'd0, cli_done}, 48'd0);
    checkOutput("t4_late_data", cli_data, 48'h5555_6666_7777);
    checkOutput("t4_late_busy", {47'd0, busy}, 48'd0);

    // Advance rr_ptr past 0, park client 3 in WAIT, then reset asynchronously.
    cli_addr = 32'h4433_2211;
    cli_req  = 4'b0010;
    tick();
    checkOutput("t6_pre_addr", {40'd0, bram_read_add}, 48'h22);
    applyStimulus(1'b1, 1'b1, 48'h0000_0000_0606);
    cli_req = 4'b1000;
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("t6_pre_done", {44'd0, cli_done}, 48'b0010);
    tick();
    tick();
    checkOutput("t6_addr3", {40'd0, bram_read_add}, 48'h44);
    applyStimulus(1'b1, 1'b0, 48'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'd0);
    checkOutput("t6_wait_busy", {47'd0, busy}, 48'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6_async_req",  {47'd0, bram_read_req}, 48'd0);
    checkOutput("t6_async_busy", {47'd0, busy}, 48'd0);
    checkOutput("t6_async_done", {44'd0, cli_done}, 48'd0);
    checkOutput("t6_async_err",  {44'd0, cli_err}, 48'd0);
    tick();
    reset   = 1'b1;
    cli_req = 4'b1111;
    tick();
    checkOutput("t6_regrant_req",  {47'd0, bram_read_req}, 48'd1);
    checkOutput("t6_regrant_addr", {40'd0, bram_read_add}, 48'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
